rom_load_sequencer: RTL and testbench

Framed download sequencer that sits between the download UART receiver and the instruction ROM write port. It parses a framed byte stream (sync, 16-bit word count, little-endian 32-bit words, optional checksum), issues one ROM write per word, and holds the CPU until a frame completes cleanly. It supervises the stream with a per-byte timeout and reports errors through a sticky code.

---
 rtl/load_pkg.sv | 21 ++
 rtl/load_timeout_cnt.sv | 30 +++
 rtl/rom_load_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_rom_load_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// Shared types and constants for the ROM download sequencer.
package load_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_WORD,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } load_state_e;

    localparam logic [7:0] SYNC_BYTE    = 8'hA5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_CHECKSUM = 2'd3;

endpackage

// File: rtl/load_timeout_cnt.sv
// Inter-byte idle counter. Clears on i_clr or whenever disabled, and flags
// expiry during the TIMEOUT_CYC-th idle cycle. The owner's registered state
// change therefore lands exactly TIMEOUT_CYC cycles after the last clear.
module load_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_cnt;

    // count idle cycles, saturating at the expiry value
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr || !i_en)
            r_cnt <= '0;
        else if (r_cnt != LAST)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/rom_load_sequencer.sv
// Framed download sequencer: sync byte, 16-bit LE word count, LE 32-bit words,
// one ROM write per word, CPU held until a frame completes cleanly.
// Optional feature macro: LOAD_CHECKSUM_EN adds a trailing 8-bit checksum byte.
//
// state   | meaning
// SYNC    | hunting for the sync byte, no timeout
// CNT_LO  | waiting for count LSB
// CNT_HI  | waiting for count MSB, range check
// WORD    | assembling words, byte index b0..b3
// CHK     | waiting for checksum byte (macro builds only)
// DONE    | frame complete, CPU released
// ERR     | error latched in err_code, CPU held, bytes ignored
module rom_load_sequencer
    import load_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned TIMEOUT_CYC = 5_000_000,
    parameter logic [7:0]  SYNC_BYTE   = load_pkg::SYNC_BYTE
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start_load,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       rom_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        err_code,
    output logic [15:0]       word_count
);
    localparam int IW = ADDR_W + 1;
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    load_state_e       r_state;
    logic [7:0]        r_cnt_lo;
    logic [1:0]        r_byte;
    logic [23:0]       r_word;
    logic [IW-1:0]     r_index;
    logic              r_rom_we;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [31:0]       r_rom_wdata;
    logic              r_cpu_hold;
    logic              r_cpu_start;
    logic              r_load_done;
    logic              r_load_err;
    logic [1:0]        r_err_code;
    logic [15:0]       r_word_count;
`ifdef LOAD_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic [15:0]   w_count;
    logic [IW-1:0] w_index_nxt;
    logic          w_to_en;
    logic          w_expired;

    assign w_count     = {rx_data, r_cnt_lo};
    assign w_index_nxt = r_index + 1'b1;
    assign w_to_en     = (r_state == ST_CNT_LO) || (r_state == ST_CNT_HI) ||
                         (r_state == ST_WORD)   || (r_state == ST_CHK);

    load_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk       (CLK),
        .rst       (RESET),
        .i_en      (w_to_en),
        .i_clr     (rx_valid || start_load),
        .o_expired (w_expired)
    );

    // frame parser, ROM write generation and registered status outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_SYNC;
            r_cnt_lo     <= '0;
            r_byte       <= '0;
            r_word       <= '0;
            r_index      <= '0;
            r_rom_we     <= 1'b0;
            r_rom_addr   <= '0;
            r_rom_wdata  <= '0;
            r_cpu_hold   <= 1'b1;
            r_cpu_start  <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_word_count <= '0;
`ifdef LOAD_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_rom_we    <= 1'b0;
            r_cpu_start <= 1'b0;
            if (start_load) begin
                r_state     <= ST_SYNC;
                r_cpu_hold  <= 1'b1;
                r_load_done <= 1'b0;
                r_load_err  <= 1'b0;
                r_err_code  <= ERR_NONE;
                r_index     <= '0;
                r_byte      <= '0;
`ifdef LOAD_CHECKSUM_EN
                r_csum      <= '0;
`endif
            end else if (w_expired) begin
                r_state    <= ST_ERR;
                r_load_err <= 1'b1;
                r_err_code <= ERR_TIMEOUT;
            end else if (rx_valid) begin
                case (r_state)
                    ST_SYNC: begin
                        if (rx_data == SYNC_BYTE)
                            r_state <= ST_CNT_LO;
                    end
                    ST_CNT_LO: begin
                        r_cnt_lo <= rx_data;
`ifdef LOAD_CHECKSUM_EN
                        r_csum   <= r_csum + rx_data;
`endif
                        r_state  <= ST_CNT_HI;
                    end
                    ST_CNT_HI: begin
                        r_word_count <= w_count;
                        r_index      <= '0;
                        r_byte       <= '0;
`ifdef LOAD_CHECKSUM_EN
                        r_csum       <= r_csum + rx_data;
`endif
                        if (w_count == 16'd0) begin
`ifdef LOAD_CHECKSUM_EN
                            r_state     <= ST_CHK;
`else
                            r_state     <= ST_DONE;
                            r_cpu_hold  <= 1'b0;
                            r_cpu_start <= 1'b1;
                            r_load_done <= 1'b1;
`endif
                        end else if (17'(w_count) > CAPACITY) begin
                            r_state    <= ST_ERR;
                            r_load_err <= 1'b1;
                            r_err_code <= ERR_OVERFLOW;
                        end else begin
                            r_state <= ST_WORD;
                        end
                    end
                    ST_WORD: begin
`ifdef LOAD_CHECKSUM_EN
                        r_csum <= r_csum + rx_data;
`endif
                        r_byte <= r_byte + 2'd1;
                        case (r_byte)
                            2'd0:    r_word[7:0]   <= rx_data;
                            2'd1:    r_word[15:8]  <= rx_data;
                            2'd2:    r_word[23:16] <= rx_data;
                            default: begin
                                r_rom_we    <= 1'b1;
                                r_rom_addr  <= r_index[ADDR_W-1:0];
                                r_rom_wdata <= {rx_data, r_word};
                                r_index     <= w_index_nxt;
                                if (17'(w_index_nxt) == 17'(r_word_count)) begin
`ifdef LOAD_CHECKSUM_EN
                                    r_state     <= ST_CHK;
`else
                                    r_state     <= ST_DONE;
                                    r_cpu_hold  <= 1'b0;
                                    r_cpu_start <= 1'b1;
                                    r_load_done <= 1'b1;
`endif
                                end
                            end
                        endcase
                    end
`ifdef LOAD_CHECKSUM_EN
                    ST_CHK: begin
                        if (rx_data == r_csum) begin
                            r_state     <= ST_DONE;
                            r_cpu_hold  <= 1'b0;
                            r_cpu_start <= 1'b1;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state    <= ST_ERR;
                            r_load_err <= 1'b1;
                            r_err_code <= ERR_CHECKSUM;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign rom_we     = r_rom_we;
    assign rom_addr   = r_rom_addr;
    assign rom_wdata  = r_rom_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign cpu_start  = r_cpu_start;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign err_code   = r_err_code;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_rom_load_sequencer.sv
module tb_rom_load_sequencer;
    localparam int ADDR_W = 10;
    localparam int TO     = 64;
    localparam int CAP    = 1 << ADDR_W;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              start_load = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_wdata;
    logic              cpu_hold;
    logic              cpu_start;
    logic              load_done;
    logic              load_err;
    logic [1:0]        err_code;
    logic [15:0]       word_count;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] obs_addr[$];
    logic [31:0]       obs_data[$];
    int                n_start = 0;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    int                m_status;   // 0 incomplete, 1 done, 2 error
    logic [1:0]        m_code;
    logic [15:0]       m_wc;

    logic [7:0] fr[$];

    rom_load_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .start_load (start_load),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rom_we     (rom_we),
        .rom_addr   (rom_addr),
        .rom_wdata  (rom_wdata),
        .cpu_hold   (cpu_hold),
        .cpu_start  (cpu_start),
        .load_done  (load_done),
        .load_err   (load_err),
        .err_code   (err_code),
        .word_count (word_count)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (rom_we) begin
            obs_addr.push_back(rom_addr);
            obs_data.push_back(rom_wdata);
        end
        if (cpu_start) n_start++;
    end

    // Reference: parse a byte list by the frame rules and predict the outcome.
    task automatic model_frame();
        int i;
        int n;
        logic [7:0] s;
        exp_addr.delete();
        exp_data.delete();
        m_status = 0;
        m_code = 2'd0;
        m_wc = 16'd0;
        i = 0;
        while (i < fr.size() && fr[i] != 8'hA5) i++;
        if (i + 2 >= fr.size()) return;
        n = int'(fr[i+1]) + 256 * int'(fr[i+2]);
        m_wc = 16'(n);
        s = fr[i+1] + fr[i+2];
        i += 3;
        if (n > CAP) begin
            m_status = 2;
            m_code = 2'd2;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (i + 3 >= fr.size()) return;
            exp_addr.push_back(ADDR_W'(k));
            exp_data.push_back({fr[i+3], fr[i+2], fr[i+1], fr[i]});
            s = s + fr[i] + fr[i+1] + fr[i+2] + fr[i+3];
            i += 4;
        end
`ifdef LOAD_CHECKSUM_EN
        if (i >= fr.size()) return;
        if (fr[i] == s) m_status = 1;
        else begin
            m_status = 2;
            m_code = 2'd3;
        end
`else
        m_status = 1;
`endif
    endtask

    task automatic build_frame(input int cnt, input int n_garbage, input bit corrupt);
        logic [7:0] s;
        logic [7:0] g;
        fr.delete();
        for (int k = 0; k < n_garbage; k++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h5A;
            fr.push_back(g);
        end
        fr.push_back(8'hA5);
        fr.push_back(8'(cnt));
        fr.push_back(8'(cnt >> 8));
        s = 8'(cnt) + 8'(cnt >> 8);
        for (int k = 0; k < 4 * cnt; k++) begin
            g = 8'($urandom_range(0, 255));
            fr.push_back(g);
            s = s + g;
        end
`ifdef LOAD_CHECKSUM_EN
        fr.push_back(corrupt ? s + 8'd1 : s);
`else
        if (corrupt) s = s;
`endif
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        rx_data = d;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        tick(gap);
    endtask

    task automatic send_frame(input int maxgap);
        for (int k = 0; k < fr.size(); k++)
            send_byte(fr[k], $urandom_range(0, maxgap));
    endtask

    task automatic rearm();
        start_load = 1'b1;
        tick(1);
        start_load = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        n_start = 0;
    endtask

    task automatic test_reset();
        total++;
        if ({cpu_hold, rom_we, cpu_start, load_done, load_err} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=10000",
                     {cpu_hold, rom_we, cpu_start, load_done, load_err});
        end
        total++;
        if ({err_code, word_count, rom_addr, rom_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_values err=%0d wc=%h addr=%h data=%h want all zero",
                     err_code, word_count, rom_addr, rom_wdata);
        end
    endtask

    task automatic test_clean_load();
        logic [7:0] b[] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00};
        rearm();
        foreach (b[k]) send_byte(b[k], 0);
`ifdef LOAD_CHECKSUM_EN
        send_byte(8'hB8, 0);
`endif
        tick(3);
        total++;
        if (obs_addr.size() !== 2) begin
            bad++;
            $display("FAIL clean_nwrites got=%0d want=2", obs_addr.size());
        end else begin
            total++;
            if (obs_addr[0] !== 0 || obs_data[0] !== 32'h00000013) begin
                bad++;
                $display("FAIL clean_w0 got=%0d:%h want=0:00000013", obs_addr[0], obs_data[0]);
            end
            total++;
            if (obs_addr[1] !== 1 || obs_data[1] !== 32'h00100093) begin
                bad++;
                $display("FAIL clean_w1 got=%0d:%h want=1:00100093", obs_addr[1], obs_data[1]);
            end
        end
        total++;
        if (n_start !== 1 || cpu_hold !== 1'b0 || load_done !== 1'b1 || word_count !== 16'd2) begin
            bad++;
            $display("FAIL clean_status got start=%0d hold=%b done=%b wc=%0d want 1 0 1 2",
                     n_start, cpu_hold, load_done, word_count);
        end
    endtask

    task automatic test_random_frames();
        for (int it = 0; it < 12; it++) begin
            rearm();
            build_frame($urandom_range(0, 6), $urandom_range(0, 3), ($urandom_range(0, 2) == 0));
            if (it == 0) begin
                fr.push_front(8'hFF);
                fr.push_front(8'h00);
            end
            model_frame();
            send_frame(3);
            tick(3);
            total++;
            if (obs_addr.size() !== exp_addr.size()) begin
                bad++;
                $display("FAIL rand%0d_nwrites got=%0d want=%0d", it, obs_addr.size(), exp_addr.size());
            end else begin
                for (int k = 0; k < exp_addr.size(); k++) begin
                    total++;
                    if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) begin
                        bad++;
                        $display("FAIL rand%0d_write%0d got=%0d:%h want=%0d:%h", it, k,
                                 obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]);
                    end
                end
            end
            total++;
            if (load_done !== (m_status == 1) || load_err !== (m_status == 2) ||
                err_code !== m_code || cpu_hold !== (m_status != 1) ||
                n_start !== int'(m_status == 1) || word_count !== m_wc) begin
                bad++;
                $display("FAIL rand%0d_status got done=%b err=%b code=%0d hold=%b start=%0d wc=%0d want status=%0d code=%0d wc=%0d",
                         it, load_done, load_err, err_code, cpu_hold, n_start, word_count,
                         m_status, m_code, m_wc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nbad;
        rearm();
        build_frame(CAP, 0, 1'b0);
        model_frame();
        send_frame(0);
        tick(3);
        nbad = 0;
        total++;
        if (obs_addr.size() !== CAP) begin
            bad++;
            $display("FAIL full_nwrites got=%0d want=%0d", obs_addr.size(), CAP);
        end else begin
            for (int k = 0; k < CAP; k++)
                if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) nbad++;
            total++;
            if (nbad !== 0) begin
                bad++;
                $display("FAIL full_writes got=%0d wrong want=0", nbad);
            end
        end
        total++;
        if (load_done !== 1'b1 || n_start !== 1 || word_count !== 16'(CAP)) begin
            bad++;
            $display("FAIL full_status got done=%b start=%0d wc=%h want 1 1 %h",
                     load_done, n_start, word_count, 16'(CAP));
        end
    endtask

    task automatic test_overflow();
        rearm();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 1);
        send_byte(8'h04, 0);
        for (int k = 0; k < 8; k++) send_byte(8'($urandom_range(0, 255)), 0);
        tick(3);
        total++;
        if (load_err !== 1'b1 || err_code !== 2'd2 || obs_addr.size() !== 0 ||
            n_start !== 0 || cpu_hold !== 1'b1 || word_count !== 16'h0401) begin
            bad++;
            $display("FAIL overflow got err=%b code=%0d writes=%0d start=%0d hold=%b wc=%h want 1 2 0 0 1 0401",
                     load_err, err_code, obs_addr.size(), n_start, cpu_hold, word_count);
        end
    endtask

    task automatic test_timeout();
        int n;
        logic [7:0] b[] = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rearm();
        foreach (b[k]) send_byte(b[k], 0);
        n = 0;
        while (n < TO + 20) begin
            tick(1);
            n++;
            if (load_err) break;
        end
        total++;
        if (n !== TO) begin
            bad++;
            $display("FAIL timeout_latency got=%0d want=%0d", n, TO);
        end
        total++;
        if (err_code !== 2'd1 || cpu_hold !== 1'b1 || obs_addr.size() !== 1 || n_start !== 0) begin
            bad++;
            $display("FAIL timeout_status got code=%0d hold=%b writes=%0d start=%0d want 1 1 1 0",
                     err_code, cpu_hold, obs_addr.size(), n_start);
        end
        for (int k = 0; k < 4; k++) send_byte(8'h77, 0);
        tick(2);
        total++;
        if (load_err !== 1'b1 || err_code !== 2'd1 || obs_addr.size() !== 1) begin
            bad++;
            $display("FAIL err_ignores_rx got err=%b code=%0d writes=%0d want 1 1 1",
                     load_err, err_code, obs_addr.size());
        end
        rearm();
        tick(1);
        total++;
        if (load_err !== 1'b0 || err_code !== 2'd0 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL rearm_after_err got err=%b code=%0d hold=%b want 0 0 1",
                     load_err, err_code, cpu_hold);
        end
    endtask

    task automatic test_collision();
        logic [7:0] b[] = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE};
        rearm();
        foreach (b[k]) send_byte(b[k], 0);
        start_load = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'hEF;
        tick(1);
        start_load = 1'b0;
        rx_valid = 1'b0;
        tick(TO + 5);
        total++;
        if (obs_addr.size() !== 0 || load_err !== 1'b0 || err_code !== 2'd0 ||
            cpu_hold !== 1'b1 || n_start !== 0) begin
            bad++;
            $display("FAIL collision got writes=%0d err=%b code=%0d hold=%b start=%0d want 0 0 0 1 0",
                     obs_addr.size(), load_err, err_code, cpu_hold, n_start);
        end
        build_frame(1, 0, 1'b0);
        model_frame();
        send_frame(1);
        tick(3);
        total++;
        if (obs_addr.size() !== 1 || load_done !== 1'b1 || n_start !== 1) begin
            bad++;
            $display("FAIL post_collision_frame got writes=%0d done=%b start=%0d want 1 1 1",
                     obs_addr.size(), load_done, n_start);
        end else begin
            total++;
            if (obs_addr[0] !== exp_addr[0] || obs_data[0] !== exp_data[0]) begin
                bad++;
                $display("FAIL post_collision_write got=%0d:%h want=%0d:%h",
                         obs_addr[0], obs_data[0], exp_addr[0], exp_data[0]);
            end
        end
    endtask

    initial begin
        tick(3);
        RESET = 1'b0;
        tick(1);
        test_reset();
        test_clean_load();
        test_random_frames();
        test_overflow();
        test_timeout();
        test_collision();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
